cpu_mem_loader: RTL and testbench

Host-side initiator for the CPU's external memory ports. It streams a program image into instruction memory and an initial data image into data memory through the `*_ext` / `*_ext_2` ports. It then drives the CPU `enable` input for a programmed number of cycles and streams a window of data memory back out. The block sits between a host word-stream interface and the `cpu` top, and is the only master of the external ports.

---
 rtl/cpu_mem_loader.sv | 158 +++++++++++++++
 tb/tb_cpu_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: streams program/data images into CPU memories, runs the CPU, dumps a data window back out.
// Defining LOADER_CHECKSUM_EN adds load_sum/dump_sum running-sum outputs.
module cpu_mem_loader #(
  parameter int I_LEN_W = 10,
  parameter int D_LEN_W = 11,
  parameter int RUN_W   = 32
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               start,
  input  logic [I_LEN_W-1:0] i_len,
  input  logic [D_LEN_W-1:0] d_len,
  input  logic [RUN_W-1:0]   run_cycles,
  input  logic [D_LEN_W-1:0] dump_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_data,
  output logic               cpu_enable,
  output logic [31:0]        addr_ext,
  output logic [31:0]        wdata_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  input  logic [31:0]        rdata_ext,
  output logic [31:0]        addr_ext_2,
  output logic [31:0]        wdata_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  input  logic [31:0]        rdata_ext_2,
  output logic               busy,
  output logic               done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]        load_sum,
  output logic [31:0]        dump_sum
`endif
);
  localparam int IDX_W = (I_LEN_W > D_LEN_W) ? I_LEN_W : D_LEN_W;
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT} state_e;
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [I_LEN_W-1:0] ilen_q, ilen_d;
  logic [D_LEN_W-1:0] dlen_q, dlen_d, dump_q, dump_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [31:0]        mdata_q, mdata_d;
  logic               done_q, done_d;
  logic [IDX_W:0]     idx_inc;
  logic [31:0]        addr;
  logic               last_i, last_d, last_m, s_fire, m_fire;
  logic               unused_rdata;
  assign unused_rdata = ^rdata_ext;
  assign idx_inc = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign addr    = 32'({idx_q, 2'b00});
  assign last_i  = idx_inc == (IDX_W+1)'(ilen_q);
  assign last_d  = idx_inc == (IDX_W+1)'(dlen_q);
  assign last_m  = idx_inc == (IDX_W+1)'(dump_q);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  // first phase with nonzero work, skipping the ones already behind us
  function automatic state_e pick(input logic d, input logic r, input logic m);
    return d ? LOAD_D : r ? RUN : m ? DUMP_RD : IDLE;
  endfunction
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ilen_q  <= '0;
      dlen_q  <= '0;
      dump_q  <= '0;
      run_q   <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ilen_q  <= ilen_d;
      dlen_q  <= dlen_d;
      dump_q  <= dump_d;
      run_q   <= run_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ilen_d  = ilen_q;
    dlen_d  = dlen_q;
    dump_d  = dump_q;
    run_d   = run_q;
    mdata_d = mdata_q;
    case (state_q)
      IDLE: if (start) begin
        ilen_d  = i_len;
        dlen_d  = d_len;
        dump_d  = dump_len;
        run_d   = run_cycles;
        idx_d   = '0;
        state_d = (i_len != '0) ? LOAD_I : pick(d_len != '0, run_cycles != '0, dump_len != '0);
      end
      LOAD_I: if (s_fire) begin
        idx_d   = last_i ? '0 : idx_inc[IDX_W-1:0];
        state_d = last_i ? pick(dlen_q != '0, run_q != '0, dump_q != '0) : LOAD_I;
      end
      LOAD_D: if (s_fire) begin
        idx_d   = last_d ? '0 : idx_inc[IDX_W-1:0];
        state_d = last_d ? pick(1'b0, run_q != '0, dump_q != '0) : LOAD_D;
      end
      RUN: begin
        run_d   = run_q - RUN_W'(1);
        state_d = (run_q == RUN_W'(1)) ? pick(1'b0, 1'b0, dump_q != '0) : RUN;
      end
      DUMP_RD: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        mdata_d = rdata_ext_2;
        state_d = DUMP_OUT;
      end
      DUMP_OUT: if (m_ready) begin
        idx_d   = last_m ? '0 : idx_inc[IDX_W-1:0];
        state_d = last_m ? IDLE : DUMP_RD;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == IDLE) && (state_q != IDLE || start);
  end
  always_comb begin
    s_ready     = state_q == LOAD_I || state_q == LOAD_D;
    wen_ext     = state_q == LOAD_I && s_valid;
    addr_ext    = (state_q == LOAD_I) ? addr : '0;
    wdata_ext   = (state_q == LOAD_I) ? s_data : '0;
    ren_ext     = 1'b0;
    wen_ext_2   = state_q == LOAD_D && s_valid;
    ren_ext_2   = state_q == DUMP_RD;
    addr_ext_2  = (state_q == LOAD_D || state_q == DUMP_RD) ? addr : '0;
    wdata_ext_2 = (state_q == LOAD_D) ? s_data : '0;
    cpu_enable  = state_q == RUN;
    m_valid     = state_q == DUMP_OUT;
    busy        = state_q != IDLE;
  end
  assign m_data = mdata_q;
  assign done   = done_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] load_sum_q, dump_sum_q;
  always_ff @(posedge clk) begin
    if (srst || (state_q == IDLE && start)) begin
      load_sum_q <= '0;
      dump_sum_q <= '0;
    end else begin
      load_sum_q <= s_fire ? load_sum_q + s_data : load_sum_q;
      dump_sum_q <= m_fire ? dump_sum_q + mdata_q : dump_sum_q;
    end
  end
  assign load_sum = load_sum_q;
  assign dump_sum = dump_sum_q;
`endif
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: directed and randomized sessions checked against a queue-based reference model.
module tb_cpu_mem_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst, start, s_valid, s_ready, m_valid, m_ready, cpu_enable;
  logic [9:0] i_len;
  logic [10:0] d_len, dump_len;
  logic [31:0] run_cycles, s_data, m_data;
  logic [31:0] addr_ext, wdata_ext, rdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] load_sum, dump_sum;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] dmem [1024];
  logic [31:0] dinit [1024];
  logic fill = 1'b0;
  logic [31:0] fixed_words [$];

  cpu_mem_loader dut (
    .clk(clk), .srst(srst), .start(start), .i_len(i_len), .d_len(d_len),
    .run_cycles(run_cycles), .dump_len(dump_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .load_sum(load_sum), .dump_sum(dump_sum)
`endif
  );

  // data SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 1024; k++) dmem[k] <= dinit[k];
    end else begin
      if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pv: s_valid percent (-1 = toggle each cycle); pm: m_ready percent
  task automatic session(input int il, input int dl, input int rc, input int dm, input int pv, input int pm,
                         input bit stall10, input int abort_at, input bit full_rate);
    logic [31:0] words [$];
    logic [31:0] ibuf [$];
    logic [31:0] dbuf [$];
    logic [63:0] iw [$];
    logic [63:0] dw [$];
    logic [31:0] mw [$];
    logic [31:0] exp_w, lsum, dsum;
    int en = 0, ren = 0, bad = 0, sbad = 0, cyc = 0, donec = -1, first_rdy = -1, first_en = -1, held = 0;
    logic pmv = 1'b0, pmr = 1'b0;
    logic [31:0] pmd = '0;
    lsum = '0;
    dsum = '0;
    for (int k = 0; k < il + dl; k++) begin
      exp_w = (k < fixed_words.size()) ? fixed_words[k] : $urandom;
      words.push_back(exp_w);
      lsum += exp_w;
      if (k < il) ibuf.push_back(exp_w); else dbuf.push_back(exp_w);
    end
    for (int k = 0; k < 1024; k++) dinit[k] = $urandom;
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    i_len = 10'(il);
    d_len = 11'(dl);
    run_cycles = 32'(rc);
    dump_len = 11'(dm);
    start = 1'b1;
    s_valid = (pv == 100);
    s_data = words.size() > 0 ? words[0] : 32'h0;
    m_ready = !stall10 && (pm == 100);
    while (cyc < 8000) begin
      @(negedge clk);
      if (wen_ext) iw.push_back({addr_ext, wdata_ext});
      if (wen_ext_2) dw.push_back({addr_ext_2, wdata_ext_2});
      if (ren_ext_2) ren++;
      if (cpu_enable) begin
        en++;
        if (first_en < 0) first_en = cyc;
      end
      if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2 || s_ready || m_valid)) bad++;
      if (ren_ext || (s_ready && m_valid)) bad++;
      if (s_ready && first_rdy < 0) first_rdy = cyc;
      if (pmv && !pmr && (!m_valid || m_data !== pmd)) sbad++;
      if (m_valid && !m_ready) held++;
      if (s_valid && s_ready) void'(words.pop_front());
      if (m_valid && m_ready) mw.push_back(m_data);
      pmv = m_valid;
      pmr = m_ready;
      pmd = m_data;
      if (done) begin
        donec = cyc;
        break;
      end
      if (abort_at >= 0 && en == abort_at) begin
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        srst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = words.size() > 0 && ((pv < 0) ? cyc[0] : ($urandom_range(99) < 32'(pv)));
      s_data = words.size() > 0 ? words[0] : $urandom;
      m_ready = (stall10 && held < 10) ? 1'b0 : ($urandom_range(99) < 32'(pm));
      cyc++;
    end
    chk("done_seen", donec >= 0, 1);
    chk("i_writes", iw.size(), il);
    for (int k = 0; k < il && k < iw.size(); k++) begin
      chk("i_addr", iw[k][63:32], 4 * k);
      chk("i_data", iw[k][31:0], ibuf[k]);
    end
    chk("d_writes", dw.size(), dl);
    for (int k = 0; k < dl && k < dw.size(); k++) begin
      chk("d_addr", dw[k][63:32], 4 * k);
      chk("d_data", dw[k][31:0], dbuf[k]);
    end
    chk("run_cycles", en, rc);
    chk("exclusive", bad, 0);
    chk("m_stable", sbad, 0);
    chk("dump_reads", ren, dm);
    chk("dump_count", mw.size(), dm);
    for (int k = 0; k < dm && k < mw.size(); k++) begin
      exp_w = (k < dl) ? dbuf[k] : dinit[k];
      dsum += exp_w;
      chk("dump_data", mw[k], exp_w);
    end
    if (stall10) chk("stall_held", held, 10);
    if (full_rate) begin
      chk("done_cycle", donec, 1 + il + dl + rc + 3 * dm);
      if (il + dl > 0) chk("first_ready", first_rdy, 1);
      if (rc > 0) chk("first_enable", first_en, 1 + il + dl);
    end
`ifdef LOADER_CHECKSUM_EN
    chk("load_sum", load_sum, lsum);
    chk("dump_sum", dump_sum, dsum);
`endif
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    srst = 1'b1;
    start = 1'b0;
    i_len = '0;
    d_len = '0;
    run_cycles = '0;
    dump_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    rdata_ext = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_cpu_enable", cpu_enable, 0);
    chk("reset_m_data", m_data, 0);
    srst = 1'b0;
    fixed_words = {32'h11, 32'h22, 32'h33, 32'hA, 32'hB};
    session(3, 2, 5, 2, 100, 100, 1'b0, -1, 1'b1);
    fixed_words = {};
    session(4, 0, 0, 0, -1, 100, 1'b0, -1, 1'b0);
    session(0, 2, 1, 3, 100, 100, 1'b1, -1, 1'b0);
    session(0, 0, 2, 0, 100, 100, 1'b0, -1, 1'b1);
    session(0, 0, 0, 0, 100, 100, 1'b0, -1, 1'b1);
    session(0, 0, 150, 0, 100, 100, 1'b0, 50, 1'b0);
    session(2, 2, 3, 2, 100, 100, 1'b0, -1, 1'b1);
    repeat (4) session($urandom_range(20), $urandom_range(20), $urandom_range(30), $urandom_range(20),
                       60, 60, 1'b0, -1, 1'b0);
    session(512, 1024, 1, 1024, 100, 100, 1'b0, -1, 1'b1);
    fixed_words = {32'hFFFFFFFF, 32'h2};
    session(1, 1, 1, 1, 100, 100, 1'b0, -1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    chk("load_sum_wrap", load_sum, 32'h1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
